rob_commit: RTL

// - In-order retirement end of rename: reorder buffer of ROB_ENTRIES slots. Hands ALLOC_W consecutive ROB IDs to the decoder.
// - Records each renamed op's old physical aliases and marks ops done on execute completion.
// - Retires up to COMMIT_W ops/cycle in program order and returns their old aliases to the decoder free pool (its cmplt_free_regs).

---
 rtl/rob_commit_pkg.sv | 16 +
 rtl/rob_commit_select.sv | 27 ++
 rtl/rob_commit.sv | 136 +++++++++++++
 3 files changed

// File: rtl/rob_commit_pkg.sv
// Shared sizing for the reorder-buffer retirement slice.
// Widths here are the defaults for rob_commit and its commit selector.
package rob_commit_pkg;

  localparam int ROB_ENTRIES  = 32;
  localparam int ROB_ID_W     = 5;
  localparam int ROB_ALLOC_W  = 4;
  localparam int ROB_COMMIT_W = 3;
  localparam int ROB_CMPLT_N  = 4;
  localparam int PR_ADDR_W    = 5;
  localparam int ROB_PAIR_W   = 2 * PR_ADDR_W;

  typedef logic [ROB_ID_W-1:0]   rob_id_t;
  typedef logic [ROB_PAIR_W-1:0] alias_pair_t;

endpackage

// File: rtl/rob_commit_select.sv
// Counts how many slots, starting at head, can retire this cycle.
// Inputs are already rotated so bit 0 is the slot at head.
module rob_commit_select #(
  parameter int COMMIT_W = 3,
  parameter int N_W      = 2
) (
  input  logic [COMMIT_W-1:0] valid_i,
  input  logic [COMMIT_W-1:0] done_i,
  output logic [N_W-1:0]      n_o
);

  logic stop;

  // The first slot that cannot retire blocks everything younger.
  always_comb begin
    n_o  = '0;
    stop = 1'b0;
    for (int k = 0; k < COMMIT_W; k++) begin
      if (!stop && valid_i[k] && done_i[k]) begin
        n_o = N_W'(k + 1);
      end else begin
        stop = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rob_commit.sv
// Reorder buffer: hands out IDs in groups, tracks completion and
// retires in program order, returning each op's old aliases.
module rob_commit
  import rob_commit_pkg::*;
#(
  parameter int ENTRIES  = ROB_ENTRIES,
  parameter int ID_W     = ROB_ID_W,
  parameter int ALLOC_W  = ROB_ALLOC_W,
  parameter int COMMIT_W = ROB_COMMIT_W,
  parameter int CMPLT_N  = ROB_CMPLT_N,
  parameter int PR_W     = PR_ADDR_W
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic [ALLOC_W*ID_W-1:0]      alloc_ids_o,
  output logic                         alloc_ready_o,
  input  logic                         alloc_valid_i,
  input  logic [ALLOC_W*2*PR_W-1:0]    alloc_old_aliases_i,
  input  logic [CMPLT_N-1:0]           cmplt_valid_i,
  input  logic [CMPLT_N*ID_W-1:0]      cmplt_ids_i,
  output logic [COMMIT_W*2*PR_W-1:0]   free_regs_o,
  output logic [COMMIT_W-1:0]          commit_valid_o,
  output logic [ID_W:0]                occupancy_o
);

  localparam int PAIR_W = 2 * PR_W;
  localparam int N_W    = $clog2(COMMIT_W + 1);

  logic [ID_W-1:0]              head_q, head_d;
  logic [ID_W-1:0]              tail_q, tail_d;
  logic [ID_W:0]                count_q, count_d;
  logic [ENTRIES-1:0]           slotValid_q;
  logic [ENTRIES-1:0]           slotDone_q;
  logic [PAIR_W-1:0]            slotOld_q [ENTRIES];
  logic [COMMIT_W*PAIR_W-1:0]   freeRegs_q, freeRegs_d;
  logic [COMMIT_W-1:0]          commitValid_q, commitValid_d;

  logic [ID_W-1:0]              headIdx [COMMIT_W];
  logic [COMMIT_W-1:0]          headValid;
  logic [COMMIT_W-1:0]          headDone;
  logic [N_W-1:0]               commitN;
  logic                         allocFire;

  // Readiness looks only at the registered count, so same-cycle commits
  // never make room for an allocation until the following cycle.
  assign alloc_ready_o  = count_q <= (ID_W+1)'(ENTRIES - ALLOC_W);
  assign occupancy_o    = count_q;
  assign free_regs_o    = freeRegs_q;
  assign commit_valid_o = commitValid_q;

  always_comb begin
    for (int i = 0; i < ALLOC_W; i++) begin
      alloc_ids_o[i*ID_W +: ID_W] = tail_q + ID_W'(i);
    end
  end

  always_comb begin
    for (int k = 0; k < COMMIT_W; k++) begin
      headIdx[k]   = head_q + ID_W'(k);
      headValid[k] = slotValid_q[headIdx[k]];
      headDone[k]  = slotDone_q[headIdx[k]];
    end
  end

  rob_commit_select #(
    .COMMIT_W (COMMIT_W),
    .N_W      (N_W)
  ) u_select (
    .valid_i (headValid),
    .done_i  (headDone),
    .n_o     (commitN)
  );

  always_comb begin
    allocFire     = alloc_valid_i && alloc_ready_o;
    head_d        = head_q + ID_W'(commitN);
    tail_d        = allocFire ? tail_q + ID_W'(ALLOC_W) : tail_q;
    count_d       = count_q + (allocFire ? (ID_W+1)'(ALLOC_W) : '0)
                    - (ID_W+1)'(commitN);
    freeRegs_d    = '0;
    commitValid_d = '0;
    for (int k = 0; k < COMMIT_W; k++) begin
      if (k < int'(commitN)) begin
        freeRegs_d[k*PAIR_W +: PAIR_W] = slotOld_q[headIdx[k]];
        commitValid_d[k]               = 1'b1;
      end
    end
  end

  // Completion, retirement and allocation never touch the same slot in one
  // cycle except completion+retire, where the retire clear must win.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      slotValid_q   <= '0;
      slotDone_q    <= '0;
      freeRegs_q    <= '0;
      commitValid_q <= '0;
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      freeRegs_q    <= freeRegs_d;
      commitValid_q <= commitValid_d;
      for (int p = 0; p < CMPLT_N; p++) begin
        if (cmplt_valid_i[p] && slotValid_q[cmplt_ids_i[p*ID_W +: ID_W]]) begin
          slotDone_q[cmplt_ids_i[p*ID_W +: ID_W]] <= 1'b1;
        end
      end
      for (int k = 0; k < COMMIT_W; k++) begin
        if (k < int'(commitN)) begin
          slotValid_q[headIdx[k]] <= 1'b0;
          slotDone_q[headIdx[k]]  <= 1'b0;
        end
      end
      if (allocFire) begin
        for (int i = 0; i < ALLOC_W; i++) begin
          slotValid_q[tail_q + ID_W'(i)] <= 1'b1;
          slotDone_q[tail_q + ID_W'(i)]  <= 1'b0;
        end
      end
    end
  end

  // Alias payload needs no reset; it is only read behind a valid bit.
  always_ff @(posedge clk) begin
    if (!rst && allocFire) begin
      for (int i = 0; i < ALLOC_W; i++) begin
        slotOld_q[tail_q + ID_W'(i)] <= alloc_old_aliases_i[i*PAIR_W +: PAIR_W];
      end
    end
  end

endmodule
